// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master, one-slave data-bus arbiter.
//   m0 is the core data port, m1 is the debug-module system-bus port.
//   Each master owns a single request slot; a request-start pulse fills the
//   slot and sets its pending bit, and further pulses are dropped until that
//   request has completed. A three-state FSM (IDLE/ISSUE/WAIT) forwards one
//   slot at a time to the downstream port and routes the completion pulse and
//   read data back to the owning master only.
//
// Optional feature: define DBUS_ARB_ROUND_ROBIN_EN to break simultaneous
//   requests round-robin (m0 wins the first tie). Without it, m1 (debug)
//   always wins a tie.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_bstart                  request-start pulse from master N
//   mN_ttype/tsize/addr/wdata  request attributes, valid with mN_bstart
//   mN_bdone, mN_rdata         completion pulse and read data to master N
//   s_bstart, s_breq           downstream start (identical)
//   s_ttype/tsize/addr/wdata   downstream request attributes
//   s_bdone, s_rdata           downstream completion and read data
//   owner                      currently granted master, held while idle
module dbus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_bstart,
  input  logic              m0_ttype,
  input  logic [1:0]        m0_tsize,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_bdone,
  output logic [31:0]       m0_rdata,
  input  logic              m1_bstart,
  input  logic              m1_ttype,
  input  logic [1:0]        m1_tsize,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_bdone,
  output logic [31:0]       m1_rdata,
  output logic              s_bstart,
  output logic              s_breq,
  output logic              s_ttype,
  output logic [1:0]        s_tsize,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  input  logic              s_bdone,
  input  logic [31:0]       s_rdata,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_nxt;
  logic   owner_nxt;
  logic   pend0, pend1;
  logic   grant;
  logic   busy;
  logic   done;

  logic              ttype0, ttype1;
  logic [1:0]        tsize0, tsize1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;

  assign busy = (state != IDLE);
  // s_bdone only means something while a transaction is outstanding.
  assign done = busy && s_bdone;

  // Tie-break between simultaneous pending requests.
`ifdef DBUS_ARB_ROUND_ROBIN_EN
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (state == IDLE && (pend0 || pend1)) begin
      last <= grant;
    end
  end

  always_comb begin
    grant = pend1;
    if (pend0 && pend1) grant = ~last;
  end
`else
  always_comb begin
    grant = pend1;
    if (pend0 && pend1) grant = 1'b1;
  end
`endif

  // Request capture: pending bits are control (reset), slots are data (no reset).
  // A pulse while the slot is pending, including in the completion cycle, is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      if (pend0) begin
        if (done && !owner) pend0 <= 1'b0;
      end else if (m0_bstart) begin
        pend0 <= 1'b1;
      end
      if (pend1) begin
        if (done && owner) pend1 <= 1'b0;
      end else if (m1_bstart) begin
        pend1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (m0_bstart && !pend0) begin
      ttype0 <= m0_ttype;
      tsize0 <= m0_tsize;
      addr0  <= m0_addr;
      wdata0 <= m0_wdata;
    end
    if (m1_bstart && !pend1) begin
      ttype1 <= m1_ttype;
      tsize1 <= m1_tsize;
      addr1  <= m1_addr;
      wdata1 <= m1_wdata;
    end
  end

  // FSM state and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          state_nxt = ISSUE;
          owner_nxt = grant;
        end
      end
      ISSUE:   state_nxt = s_bdone ? IDLE : WAIT;
      WAIT:    if (s_bdone) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream drive: the owner's slot while busy, all zero while idle so
  // that reset (which forces IDLE) clears every output asynchronously.
  always_comb begin
    s_bstart = (state == ISSUE);
    s_breq   = s_bstart;
    s_ttype  = 1'b0;
    s_tsize  = 2'd0;
    s_addr   = '0;
    s_wdata  = 32'd0;
    if (busy) begin
      s_ttype = owner ? ttype1 : ttype0;
      s_tsize = owner ? tsize1 : tsize0;
      s_addr  = owner ? addr1  : addr0;
      s_wdata = owner ? wdata1 : wdata0;
    end
  end

  // Completion routing to the owner only.
  assign m0_bdone = done && !owner;
  assign m1_bdone = done && owner;
  assign m0_rdata = m0_bdone ? s_rdata : 32'd0;
  assign m1_rdata = m1_bdone ? s_rdata : 32'd0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: self-checking bench for dbus_arbiter.
//   A per-cycle vector table covers single transactions and tie arbitration;
//   hand-written sequences cover a request during WAIT, dropped repeat
//   requests, and reset asserted mid-transaction.
module tb_dbus_arbiter;

  logic        clk, rst_n;
  logic        m0_bstart, m0_ttype, m1_bstart, m1_ttype;
  logic [1:0]  m0_tsize, m1_tsize;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_bdone, m1_bdone;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_bstart, s_breq, s_ttype, s_bdone, owner;
  logic [1:0]  s_tsize;
  logic [31:0] s_addr, s_wdata, s_rdata;

  dbus_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_bstart(m0_bstart), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_bdone(m0_bdone), .m0_rdata(m0_rdata),
    .m1_bstart(m1_bstart), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_bdone(m1_bdone), .m1_rdata(m1_rdata),
    .s_bstart(s_bstart), .s_breq(s_breq), .s_ttype(s_ttype), .s_tsize(s_tsize),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_bdone(s_bdone), .s_rdata(s_rdata),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner of the first simultaneous request.
`ifdef DBUS_ARB_ROUND_ROBIN_EN
  localparam logic WIN = 1'b0;
`else
  localparam logic WIN = 1'b1;
`endif
  localparam logic LOS = ~WIN;

  logic [135:0] outv;
  assign outv = {s_bstart, s_breq, s_ttype, s_tsize, s_addr, s_wdata, owner,
                 m0_bdone, m0_rdata, m1_bdone, m1_rdata};

  typedef struct {
    logic         b0, b1, t0, t1, sd;
    logic [1:0]   z0, z1;
    logic [31:0]  a0, a1, w0, w1, sr;
    logic [135:0] exp;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [135:0] ex(input logic sb, input logic tt, input logic [1:0] ts,
                                      input logic [31:0] a, input logic [31:0] wd, input logic own,
                                      input logic d0, input logic [31:0] r0,
                                      input logic d1, input logic [31:0] r1);
    return {sb, sb, tt, ts, a, wd, own, d0, r0, d1, r1};
  endfunction

  function automatic logic [135:0] ex0(input logic own);
    return ex(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, own, 1'b0, 32'd0, 1'b0, 32'd0);
  endfunction

  // Tie-round read data and expected ISSUE-with-completion outputs.
  function automatic logic [31:0] rdc(input logic m, input logic r);
    return 32'h5555_0000 | {30'd0, m, r};
  endfunction

  function automatic logic [135:0] exc(input logic m, input logic r);
    logic [31:0] a;
    a = (m ? 32'h0000_0200 : 32'h0000_0100) + (r ? 32'd4 : 32'd0);
    return ex(1'b1, ~m, m ? 2'd0 : 2'd1, a, m ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0, m,
              ~m, m ? 32'd0 : rdc(m, r), m, m ? rdc(m, r) : 32'd0);
  endfunction

  task automatic row(input logic sd, input logic [31:0] sr, input logic [135:0] e);
    vec_t v;
    v = '{default: '0};
    v.sd = sd; v.sr = sr; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic req(input logic b0, input logic [31:0] a0, input logic [31:0] w0,
                     input logic t0, input logic [1:0] z0,
                     input logic b1, input logic [31:0] a1, input logic [31:0] w1,
                     input logic t1, input logic [1:0] z1, input logic [135:0] e);
    vec_t v;
    v = '{default: '0};
    v.b0 = b0; v.a0 = a0; v.w0 = w0; v.t0 = t0; v.z0 = z0;
    v.b1 = b1; v.a1 = a1; v.w1 = w1; v.t1 = t1; v.z1 = z1;
    v.exp = e;
    vq.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    m0_bstart = 1'b0;
    m1_bstart = 1'b0;
    s_bdone   = 1'b0;
    s_rdata   = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_bstart = 1'b0; m0_ttype = 1'b0; m0_tsize = 2'd0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_bstart = 1'b0; m1_ttype = 1'b0; m1_tsize = 2'd0; m1_addr = 32'd0; m1_wdata = 32'd0;
    s_bdone = 1'b0; s_rdata = 32'd0;

    // m0 word read, completion three cycles after s_bstart.
    req(1'b1, 32'h8000_0010, 32'd0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, ex0(1'b0));
    row(1'b0, 32'd0, ex0(1'b0));
    row(1'b0, 32'd0, ex(1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0));
    row(1'b0, 32'd0, ex(1'b0, 1'b0, 2'd2, 32'h8000_0010, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0));
    row(1'b0, 32'h1111_1111, ex(1'b0, 1'b0, 2'd2, 32'h8000_0010, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0));
    row(1'b1, 32'hDEAD_BEEF, ex(1'b0, 1'b0, 2'd2, 32'h8000_0010, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0));
    row(1'b1, 32'hFFFF_FFFF, ex0(1'b0));
    // m1 word write completed during ISSUE: straight back to IDLE.
    req(1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b1, 32'h2000_0000, 32'h1234_5678, 1'b1, 2'd2, ex0(1'b0));
    row(1'b0, 32'd0, ex0(1'b0));
    row(1'b1, 32'hCAFE_0001, ex(1'b1, 1'b1, 2'd2, 32'h2000_0000, 32'h1234_5678, 1'b1, 1'b0, 32'd0, 1'b1, 32'hCAFE_0001));
    row(1'b0, 32'd0, ex0(1'b1));
    // Two rounds of simultaneous requests.
    req(1'b1, 32'h100, 32'hA0A0_A0A0, 1'b1, 2'd1, 1'b1, 32'h200, 32'hB1B1_B1B1, 1'b0, 2'd0, ex0(1'b1));
    row(1'b0, 32'd0, ex0(1'b1));
    row(1'b1, rdc(WIN, 1'b0), exc(WIN, 1'b0));
    row(1'b0, 32'd0, ex0(WIN));
    row(1'b1, rdc(LOS, 1'b0), exc(LOS, 1'b0));
    req(1'b1, 32'h104, 32'hA0A0_A0A0, 1'b1, 2'd1, 1'b1, 32'h204, 32'hB1B1_B1B1, 1'b0, 2'd0, ex0(LOS));
    row(1'b0, 32'd0, ex0(LOS));
    row(1'b1, rdc(WIN, 1'b1), exc(WIN, 1'b1));
    row(1'b0, 32'd0, ex0(WIN));
    row(1'b1, rdc(LOS, 1'b1), exc(LOS, 1'b1));
    row(1'b0, 32'd0, ex0(LOS));

    #2;
    chk("reset outputs", outv, 136'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      m0_bstart = vq[i].b0; m0_addr = vq[i].a0; m0_wdata = vq[i].w0;
      m0_ttype  = vq[i].t0; m0_tsize = vq[i].z0;
      m1_bstart = vq[i].b1; m1_addr = vq[i].a1; m1_wdata = vq[i].w1;
      m1_ttype  = vq[i].t1; m1_tsize = vq[i].z1;
      s_bdone   = vq[i].sd; s_rdata = vq[i].sr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outv, vq[i].exp);
    end

    // m1 requests during m0 WAIT, repeats before and at its own completion.
    next_cycle();
    m0_bstart = 1'b1; m0_addr = 32'h3000_0000; m0_ttype = 1'b0; m0_tsize = 2'd2;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("D m0 issue", {s_bstart, owner, s_addr}, {1'b1, 1'b0, 32'h3000_0000});
    next_cycle();
    m1_bstart = 1'b1; m1_addr = 32'h4000_0004; m1_wdata = 32'h77; m1_ttype = 1'b1; m1_tsize = 2'd2;
    @(negedge clk);
    chk("D m0 wait", {s_bstart, s_addr}, {1'b0, 32'h3000_0000});
    next_cycle();
    s_bdone = 1'b1; s_rdata = 32'h0BAD_F00D;
    m1_bstart = 1'b1; m1_addr = 32'h4000_0008; m1_wdata = 32'h88;
    @(negedge clk);
    chk("D m0 done", {m0_bdone, m0_rdata, m1_bdone, m1_rdata}, {1'b1, 32'h0BAD_F00D, 1'b0, 32'd0});
    next_cycle();
    @(negedge clk);
    chk("D idle", {s_bstart, s_addr}, 33'd0);
    next_cycle();
    s_bdone = 1'b1; s_rdata = 32'h1357_9BDF;
    m1_bstart = 1'b1; m1_addr = 32'h4000_000C; m1_wdata = 32'h99;
    @(negedge clk);
    chk("D m1 issue", {s_bstart, owner, s_ttype, s_addr, s_wdata},
        {1'b1, 1'b1, 1'b1, 32'h4000_0004, 32'h77});
    chk("D m1 done", {m1_bdone, m1_rdata, m0_bdone}, {1'b1, 32'h1357_9BDF, 1'b0});
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("D no reissue %0d", k), {s_bstart, s_addr}, 33'd0);
    end

    // Reset asserted during WAIT.
    next_cycle();
    m1_bstart = 1'b1; m1_addr = 32'h5000_0000; m1_wdata = 32'h99; m1_ttype = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("E m1 issue", {s_bstart, owner, s_addr}, {1'b1, 1'b1, 32'h5000_0000});
    next_cycle();
    @(negedge clk);
    chk("E m1 wait", {s_bstart, s_breq, owner, s_addr}, {1'b0, 1'b0, 1'b1, 32'h5000_0000});
    #1;
    rst_n = 1'b0;
    s_bdone = 1'b1; s_rdata = 32'hAAAA_AAAA;
    #1;
    chk("E async reset", outv, 136'd0);
    @(posedge clk);
    #1;
    chk("E held in reset", outv, 136'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    s_bdone = 1'b1; s_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("E stray bdone", outv, 136'd0);
    next_cycle();
    m0_bstart = 1'b1; m0_addr = 32'h6000_0000; m0_ttype = 1'b0; m0_tsize = 2'd2;
    next_cycle();
    @(negedge clk);
    chk("E idle after req", {s_bstart, owner}, 2'b00);
    next_cycle();
    s_bdone = 1'b1; s_rdata = 32'h2468_ACE0;
    @(negedge clk);
    chk("E m0 issue", {s_bstart, owner, s_addr}, {1'b1, 1'b0, 32'h6000_0000});
    chk("E m0 done", {m0_bdone, m0_rdata, m1_bdone}, {1'b1, 32'h2468_ACE0, 1'b0});
    next_cycle();
    @(negedge clk);
    chk("E final idle", outv, ex0(1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, width of all address buses.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 m0_bstart, m1_bstart  in  1  request-start pulse; m0 is the core data port, m1 is the debug-module system-bus port.
REQ-005 m0_ttype, m1_ttype  in  1  READ=0 / WRITE=1, valid with bstart.
REQ-006 m0_tsize, m1_tsize  in  2  BYTE/HALF/WORD, valid with bstart.
REQ-007 m0_addr, m1_addr  in  ADDR_W;  m0_wdata, m1_wdata  in  32;  valid with bstart.
REQ-008 m0_bdone, m1_bdone  out  1  completion pulse to the owning master only.
REQ-009 m0_rdata, m1_rdata  out  32  read data, valid with the matching bdone.
REQ-010 s_bstart, s_breq  out  1  downstream start; both are driven identically.
REQ-011 s_ttype  out  1;  s_tsize  out  2;  s_addr  out  ADDR_W;  s_wdata  out  32.
REQ-012 s_bdone  in  1;  s_rdata  in  32  downstream completion and read data.
REQ-013 owner  out  1  master currently granted (0 or 1); holds the last value when idle.

Function
REQ-014 A bstart pulse on mN sets pendN and captures that master's ttype, tsize, addr and wdata into a per-master slot.
REQ-015 While pendN is set, a further mN_bstart is ignored and the slot is not overwritten.
REQ-016 The FSM has three states: IDLE, ISSUE and WAIT.
REQ-017 IDLE -> ISSUE when either pend is set; the grant is decided in that cycle and loaded into owner.
REQ-018 ISSUE lasts exactly one cycle; in it s_bstart=s_breq=1 and s_* carry the owner's slot.
REQ-019 If s_bdone=1 during ISSUE, the transaction completes immediately and the FSM returns to IDLE; otherwise ISSUE -> WAIT.
REQ-020 WAIT -> IDLE on s_bdone=1.
REQ-021 In WAIT, s_bstart=0 and s_addr, s_wdata, s_ttype and s_tsize stay stable.
REQ-022 On completion, m[owner]_bdone = s_bdone and m[owner]_rdata = s_rdata in the same cycle (combinational); pend[owner] clears at the following edge.
REQ-023 The non-owner's bdone is 0 and its rdata is 0.
REQ-024 Minimum latency: mN_bstart at cycle N, s_bstart at N+2, mN_bdone no earlier than N+2.
REQ-025 A request arriving in the same cycle its master's completion is signalled is ignored.
REQ-026 s_bdone in IDLE is ignored.
REQ-027 If both pend bits are set in IDLE, the grant follows the arbitration policy in REQ-031/REQ-032.
REQ-028 A request from the non-owner arriving during ISSUE or WAIT is captured and served after the current transaction, with no lost cycles beyond the return to IDLE.

Reset
REQ-029 While rst_n is low: FSM=IDLE, pend0=pend1=0, owner=0, all s_* outputs=0, all m*_bdone=0 and all m*_rdata=0.
REQ-030 When reset asserts mid-transaction, the transaction is abandoned with no bdone, and any subsequent s_bdone is ignored because the FSM is in IDLE.

Configuration
REQ-031 With DBUS_ARB_ROUND_ROBIN_EN defined, a simultaneous grant goes to the master not served last; a last-served register resets to 1, so m0 wins the first tie.
REQ-032 Without DBUS_ARB_ROUND_ROBIN_EN, a simultaneous grant always goes to m1 (debug), and the last-served register is not implemented.

Verification
REQ-033 m0 read, addr 0x8000_0010, s_bdone 3 cycles after s_bstart with s_rdata 0xDEAD_BEEF -> m0_bdone=1 with m0_rdata=0xDEAD_BEEF; m1_bdone stays 0.
REQ-034 s_bdone asserted during ISSUE for m1 write 0x1234_5678 to 0x2000_0000 -> m1_bdone in the same cycle; FSM returns to IDLE with no WAIT cycle.
REQ-035 m0 and m1 pulse bstart in the same cycle, twice in succession -> fixed build: m1, m0, m1, m0; RR build: m0, m1, m0, m1.
REQ-036 m1 pulses bstart during m0's WAIT, and m1 pulses again before its own completion -> m1 is served once with its first address; the second pulse is dropped.
REQ-037 rst_n pulsed low during WAIT -> all outputs go to 0 asynchronously; a later s_bdone produces no m*_bdone; the next request proceeds normally.
